imem_bank: RTL and testbench
============================

IMEM_BANK -- requirements
Module: imem_bank

Interface
REQ-001 The block SHALL take parameter DEPTH, default 128, as the number of 32-bit instruction words (power of two, 16..4096).
REQ-002 The block SHALL take parameter AW, default $clog2(DEPTH), as the word-index width.
REQ-003 The block SHALL take parameter LEN_W, default AW+1, as the load-length width.
REQ-004 The block SHALL have port clk  in  1  as the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset  in  1  as the reset, asynchronous and active-high.
REQ-006 The block SHALL have port pc  in  32  as the byte address of the fetch.
REQ-007 The block SHALL have port fetch_en  in  1  as the fetch request.
REQ-008 The block SHALL have port stall  in  1  to hold the current fetch output.
REQ-009 The block SHALL have port flush  in  1  to squash the next fetch output to NOP.
REQ-010 The block SHALL have port instruction  out  32  as the registered fetched word.
REQ-011 The block SHALL have port inst_valid  out  1  to qualify instruction.
REQ-012 The block SHALL have port fetch_fault  out  1  to flag a misaligned or out-of-range pc for the current output.
REQ-013 The block SHALL have port load_start  in  1  as the single-cycle pulse that begins a program load.
REQ-014 The block SHALL have port load_len  in  LEN_W  as the number of words to load, sampled with load_start.
REQ-015 The block SHALL have port load_valid  in  1  as the load word valid.
REQ-016 The block SHALL have port load_data  in  32  as the load word.
REQ-017 The block SHALL have port load_ready  out  1  to indicate the block accepts a load word.
REQ-018 The block SHALL have port load_busy  out  1  high while in LOAD.
REQ-019 The block SHALL have port load_done  out  1  as a one-cycle pulse on load completion.

Function
REQ-020 The block SHALL run a load FSM with states IDLE, LOAD and DONE.
REQ-021 IDLE->LOAD SHALL occur on load_start; ptr SHALL be set to 0 and cnt to load_len.
REQ-022 IDLE->DONE SHALL occur instead when load_start arrives with load_len==0.
REQ-023 In LOAD, load_ready SHALL be 1; each cycle with load_valid&&load_ready SHALL write mem[ptr]=load_data, increment ptr and decrement cnt.
REQ-024 LOAD->DONE SHALL occur on the accepting cycle where cnt==1 or ptr==DEPTH-1; words beyond DEPTH are never accepted.
REQ-025 DONE SHALL assert load_done for exactly one cycle, then return to IDLE.
REQ-026 load_start SHALL be ignored outside IDLE.
REQ-027 Fetch SHALL have 1-cycle latency: in IDLE with fetch_en=1, stall=0 and flush=0, the next edge SHALL register mem[pc[AW+1:2]] with inst_valid=1.
REQ-028 A fetch SHALL fault when pc[1:0]!=0 or pc[31:2]>=DEPTH; on a fault the output SHALL be instruction=32'h00000013 (NOP), inst_valid=1 and fetch_fault=1.
REQ-029 When stall=1 and flush=0, all fetch outputs SHALL hold their values.
REQ-030 flush=1 SHALL have priority over stall and fetch_en: the next edge SHALL give instruction=NOP, inst_valid=0 and fetch_fault=0.
REQ-031 When fetch_en=0 (not stalled), the next edge SHALL give inst_valid=0 and instruction=NOP.
REQ-032 While in LOAD or DONE, fetch outputs SHALL be NOP with inst_valid=0 and fetch_fault=0; a fetch on the same edge as IDLE->LOAD SHALL still complete normally.
REQ-033 Memory SHALL initialise to NOP in every word at time zero and be read synchronously; no read-during-write bypass is needed, because fetch is disabled while loading.

Reset
REQ-034 On reset, the outputs SHALL be instruction=NOP, inst_valid=0, fetch_fault=0, load_ready=0, load_busy=0 and load_done=0.
REQ-035 On reset, state SHALL be IDLE and ptr=cnt=0.
REQ-036 Reset SHALL NOT clear memory contents; a reset mid-LOAD SHALL abort the load, keep the words already written, and produce no load_done.

Structure
REQ-037 Package imem_pkg SHALL hold the NOP constant 32'h00000013, the load_state_t enum (IDLE/LOAD/DONE) and RV32 opcode localparams.
REQ-038 The FSM, ptr and cnt SHALL live in sub-module imem_load_ctrl, which drives the write enable and address and the load_ready, load_busy and load_done outputs.
REQ-039 The memory array and fetch register SHALL remain in imem_bank.

Verification
REQ-040 The bench SHALL cover: load_start with load_len=3 and words 0x00100093, 0x00108113, 0x002081B3 with load_valid held -> load_done pulse 4 cycles after load_start; then fetch pc=0,4,8 -> those words one cycle later, inst_valid=1.
REQ-041 The bench SHALL cover: fetch pc=0x6 -> instruction=0x00000013, fetch_fault=1; fetch pc=4*DEPTH -> same.
REQ-042 The bench SHALL cover: stall high for 3 cycles during sequential fetch -> instruction constant for 3 cycles; stall and flush together -> NOP, inst_valid=0.
REQ-043 The bench SHALL cover: load_len=DEPTH+5 -> exactly DEPTH words accepted, load_ready drops, load_done pulses once.
REQ-044 The bench SHALL cover: reset asserted after 2 of 5 words -> state IDLE, no load_done, mem[0..1] new, mem[2] still NOP.
REQ-045 The bench SHALL cover: load_len=0 -> load_done the cycle after load_start, memory unchanged; load_start during LOAD ignored.

Source files
------------

// File: rtl/imem_pkg.sv
// +----------------------------------------------------------------------+
// | imem_pkg : shared constants and load-state type for the imem bank     |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package imem_pkg;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } load_state_t;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

`default_nettype wire

// File: rtl/imem_load_ctrl.sv
// +----------------------------------------------------------------------+
// | imem_load_ctrl : program-load sequencer, drives the memory write port |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module imem_load_ctrl
   import imem_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(DEPTH),
   parameter int LEN_W = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_start,
   input  logic [LEN_W-1:0] load_len,
   input  logic             load_valid,
   output logic             wr_en,
   output logic [AW-1:0]    wr_addr,
   output logic             load_ready,
   output logic             load_busy,
   output logic             load_done
);

   load_state_t      state;
   logic [AW-1:0]    ptr;
   logic [LEN_W-1:0] cnt;

   // load_ready is high exactly in LOAD, so it doubles as the state qualifier
   assign wr_en   = load_ready && load_valid;
   assign wr_addr = ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ptr        <= '0;
         cnt        <= '0;
         load_ready <= 1'b0;
         load_busy  <= 1'b0;
         load_done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_start) begin
                  ptr <= '0;
                  cnt <= load_len;
                  if (load_len == '0) begin
                     state     <= DONE;
                     load_done <= 1'b1;
                  end else begin
                     state      <= LOAD;
                     load_ready <= 1'b1;
                     load_busy  <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (load_valid) begin
                  ptr <= ptr + 1'b1;
                  cnt <= cnt - 1'b1;
                  // the last memory slot ends the load even if words remain
                  if (cnt == LEN_W'(1) || ptr == '1) begin
                     state      <= DONE;
                     load_ready <= 1'b0;
                     load_busy  <= 1'b0;
                     load_done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state     <= IDLE;
               load_done <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               load_ready <= 1'b0;
               load_busy  <= 1'b0;
               load_done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/imem_bank.sv
// +----------------------------------------------------------------------+
// | imem_bank : loadable instruction memory with a registered fetch port  |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module imem_bank
   import imem_pkg::*;
#(
   parameter int DEPTH = 128,
   parameter int AW    = $clog2(DEPTH),
   parameter int LEN_W = AW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pc,
   input  logic             fetch_en,
   input  logic             stall,
   input  logic             flush,
   output logic [31:0]      instruction,
   output logic             inst_valid,
   output logic             fetch_fault,
   input  logic             load_start,
   input  logic [LEN_W-1:0] load_len,
   input  logic             load_valid,
   input  logic [31:0]      load_data,
   output logic             load_ready,
   output logic             load_busy,
   output logic             load_done
);

   // Power-up contents only; reset deliberately leaves the array alone.
   logic [31:0] mem [DEPTH] = '{default: NOP};

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_idx;
   logic          addr_fault;
   logic          loading;

   assign rd_idx     = pc[AW+1:2];
   assign addr_fault = (pc[1:0] != 2'b00) || (pc[31:AW+2] != '0);
   assign loading    = load_busy || load_done;

   imem_load_ctrl #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .LEN_W (LEN_W)
   ) u_load_ctrl (
      .clk        (clk),
      .reset      (reset),
      .load_start (load_start),
      .load_len   (load_len),
      .load_valid (load_valid),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .load_ready (load_ready),
      .load_busy  (load_busy),
      .load_done  (load_done)
   );

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= load_data;
      end
   end

   // Blocking on the registered LOAD/DONE flags lets a fetch issued on the
   // IDLE->LOAD edge still complete.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instruction <= NOP;
         inst_valid  <= 1'b0;
         fetch_fault <= 1'b0;
      end else if (flush || loading) begin
         instruction <= NOP;
         inst_valid  <= 1'b0;
         fetch_fault <= 1'b0;
      end else if (stall) begin
         instruction <= instruction;
         inst_valid  <= inst_valid;
         fetch_fault <= fetch_fault;
      end else if (!fetch_en) begin
         instruction <= NOP;
         inst_valid  <= 1'b0;
         fetch_fault <= 1'b0;
      end else if (addr_fault) begin
         instruction <= NOP;
         inst_valid  <= 1'b1;
         fetch_fault <= 1'b1;
      end else begin
         instruction <= mem[rd_idx];
         inst_valid  <= 1'b1;
         fetch_fault <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_bank.sv
// +----------------------------------------------------------------------+
// | tb_imem_bank : randomized self-checking bench for imem_bank           |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_imem_bank;
   import imem_pkg::*;

   localparam int DEPTH = 128;
   localparam int AW    = $clog2(DEPTH);
   localparam int LEN_W = AW + 1;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      pc;
   logic             fetch_en, stall, flush;
   logic [31:0]      instruction;
   logic             inst_valid, fetch_fault;
   logic             load_start;
   logic [LEN_W-1:0] load_len;
   logic             load_valid;
   logic [31:0]      load_data;
   logic             load_ready, load_busy, load_done;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: word array plus the expected fetch-port register.
   logic [31:0] model_mem [DEPTH];
   logic [31:0] exp_instr;
   logic        exp_valid, exp_fault;
   logic [31:0] words_q [$];

   always #5 clk = ~clk;

   imem_bank #(.DEPTH(DEPTH), .AW(AW), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset), .pc(pc), .fetch_en(fetch_en), .stall(stall),
      .flush(flush), .instruction(instruction), .inst_valid(inst_valid),
      .fetch_fault(fetch_fault), .load_start(load_start), .load_len(load_len),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .load_busy(load_busy), .load_done(load_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_fetch(input string tag);
      check({tag, "_instr"}, instruction, exp_instr);
      check({tag, "_valid"}, 32'(inst_valid), 32'(exp_valid));
      check({tag, "_fault"}, 32'(fetch_fault), 32'(exp_fault));
   endtask

   task automatic fetch_step(input logic [31:0] a, input logic en, input logic st, input logic fl);
      pc = a; fetch_en = en; stall = st; flush = fl;
      tick();
      if (fl) begin
         exp_instr = NOP; exp_valid = 1'b0; exp_fault = 1'b0;
      end else if (st) begin
         // previous expectation stands
      end else if (!en) begin
         exp_instr = NOP; exp_valid = 1'b0; exp_fault = 1'b0;
      end else if (a[1:0] != 2'b00 || (a >> 2) >= DEPTH) begin
         exp_instr = NOP; exp_valid = 1'b1; exp_fault = 1'b1;
      end else begin
         exp_instr = model_mem[a >> 2]; exp_valid = 1'b1; exp_fault = 1'b0;
      end
      check_fetch("fetch");
      stall = 1'b0; flush = 1'b0;
   endtask

   // Runs a load of len words; words_q supplies data first, then random words.
   task automatic load_prog(input int len, input int abort_after, input bit gaps, input bit restart);
      int          acc = 0;
      int          edges = 0;
      int          exp_n;
      bit          v;
      bit          restarted = 0;
      logic [31:0] word;
      logic [31:0] spc;
      exp_n = (len > DEPTH) ? DEPTH : len;
      spc = 32'($urandom_range(0, DEPTH - 1)) << 2;
      pc = spc; fetch_en = 1'b1; stall = 1'b0; flush = 1'b0;
      load_start = 1'b1; load_len = LEN_W'(len);
      load_valid = 1'b1; load_data = $urandom;
      tick(); edges++;
      load_start = 1'b0;
      exp_instr = model_mem[spc >> 2]; exp_valid = 1'b1; exp_fault = 1'b0;
      check_fetch("ld_start_fetch");
      check("ld_start_done", 32'(load_done), (exp_n == 0) ? 32'd1 : 32'd0);
      check("ld_start_busy", 32'(load_busy), (exp_n == 0) ? 32'd0 : 32'd1);
      check("ld_start_ready", 32'(load_ready), (exp_n == 0) ? 32'd0 : 32'd1);
      exp_instr = NOP; exp_valid = 1'b0; exp_fault = 1'b0;
      while (acc < exp_n && edges < 4 * DEPTH) begin
         if (abort_after >= 0 && acc == abort_after) break;
         v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         word = (acc < words_q.size()) ? words_q[acc] : $urandom;
         load_valid = v; load_data = word;
         if (restart && acc == 1 && !restarted) begin
            load_start = 1'b1; load_len = LEN_W'(1); restarted = 1;
         end
         tick(); edges++;
         load_start = 1'b0;
         if (v) begin
            model_mem[acc] = word;
            acc++;
         end
         check_fetch("ld_blocked");
         check("ld_done", 32'(load_done), (acc == exp_n) ? 32'd1 : 32'd0);
         check("ld_busy", 32'(load_busy), (acc == exp_n) ? 32'd0 : 32'd1);
         check("ld_ready", 32'(load_ready), (acc == exp_n) ? 32'd0 : 32'd1);
      end
      if (abort_after >= 0) begin
         load_valid = 1'b0; fetch_en = 1'b0;
         reset = 1'b1;
         #2;
         check("abort_busy", 32'(load_busy), 32'd0);
         check("abort_ready", 32'(load_ready), 32'd0);
         check("abort_done", 32'(load_done), 32'd0);
         tick(); tick();
         reset = 1'b0;
         for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1; load_data = $urandom;
            tick();
            check("abort_no_done", 32'(load_done), 32'd0);
            check("abort_idle_ready", 32'(load_ready), 32'd0);
         end
         load_valid = 1'b0;
         check_fetch("abort_fetch");
         return;
      end
      check("ld_completed", 32'(acc), 32'(exp_n));
      if (!gaps) check("done_latency", 32'(edges), 32'(exp_n + 1));
      // Extra words offered after completion must be ignored.
      load_valid = 1'b1; load_data = $urandom;
      tick();
      check_fetch("ld_done_cycle");
      check("ld_done_drop", 32'(load_done), 32'd0);
      check("ld_after_ready", 32'(load_ready), 32'd0);
      check("ld_after_busy", 32'(load_busy), 32'd0);
      load_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] a;
      int          r;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
      reset = 1'b1; pc = '0; fetch_en = 1'b0; stall = 1'b0; flush = 1'b0;
      load_start = 1'b0; load_len = '0; load_valid = 1'b0; load_data = '0;
      exp_instr = NOP; exp_valid = 1'b0; exp_fault = 1'b0;
      tick(); tick();
      check_fetch("rst");
      check("rst_ready", 32'(load_ready), 32'd0);
      check("rst_busy", 32'(load_busy), 32'd0);
      check("rst_done", 32'(load_done), 32'd0);
      reset = 1'b0;
      tick();
      check_fetch("rst_release");

      // zero-length load: done next cycle, memory untouched
      load_prog(0, -1, 0, 0);
      for (int i = 0; i < 4; i++) fetch_step(32'(i) << 2, 1'b1, 1'b0, 1'b0);

      // reset after two of five words
      load_prog(5, 2, 0, 0);
      for (int i = 0; i < 3; i++) fetch_step(32'(i) << 2, 1'b1, 1'b0, 1'b0);
      check("abort_mem2_nop", model_mem[2], NOP);

      // three-word program, with a stray load_start mid-load
      words_q = '{32'h0010_0093, 32'h0010_8113, 32'h0020_81B3};
      load_prog(3, -1, 0, 1);
      words_q = {};
      for (int i = 0; i < 3; i++) fetch_step(32'(i) << 2, 1'b1, 1'b0, 1'b0);
      check("prog_word2", exp_instr, 32'h0020_81B3);

      // faulting addresses
      fetch_step(32'h6, 1'b1, 1'b0, 1'b0);
      fetch_step(32'(4 * DEPTH), 1'b1, 1'b0, 1'b0);

      // stall holds for three cycles, then stall+flush squashes
      fetch_step(32'h0, 1'b1, 1'b0, 1'b0);
      fetch_step(32'h4, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) fetch_step(32'h8, 1'b1, 1'b1, 1'b0);
      check("stall_held", instruction, 32'h0010_8113);
      fetch_step(32'h8, 1'b1, 1'b0, 1'b0);
      fetch_step(32'hC, 1'b1, 1'b1, 1'b1);

      // overlong load with random valid gaps fills exactly DEPTH words
      load_prog(DEPTH + 5, -1, 1, 0);

      // randomized fetch traffic against the model
      for (int n = 0; n < 400; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
         else if (r == 7) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
         else if (r == 8) a = $urandom | 32'(4 * DEPTH);
         else             a = 32'(4 * DEPTH);
         fetch_step(a, 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 9) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
